sd_tx_wb_fetcher: RTL and testbench
===================================

# sd_tx_wb_fetcher

Wishbone-master read engine for the SD transmit path: fetches consecutive 32-bit words from system memory starting at a programmed base address and pushes them into an internal dual-clock FIFO. The SD data-serial transmitter drains that FIFO in the `sd_clk` domain. It is the transmit-side counterpart of the receive filler, which writes FIFO data out to memory. It sits between the SD data master (`en`, `adr`) and the serial transmitter.

## Interface
- `DEPTH_LOG2`, 3: FIFO depth is 2^DEPTH_LOG2 words (8).
- `MEM_OFFSET`, 4: byte increment applied to the address after each completed read.
- `clk  in  1`: Wishbone and control clock.
- `rst  in  1`: Reset, asynchronous, active-high. Resets both clock domains.
- `m_wb_adr_o  out  32`: Equals `adr + offset`, combinational, modulo 2^32.
- `m_wb_we_o  out  1`: Constant 0 (reads only).
- `m_wb_dat_i  in  32`: Read data, sampled on the `clk` edge where `m_wb_ack_i`=1.
- `m_wb_cyc_o` / `m_wb_stb_o`  `out  1`: Bus request, always equal to each other.
- `m_wb_ack_i  in  1`: Slave acknowledge.
- `m_wb_cti_o  out  3`: Constant 3'b000 (classic cycle).
- `m_wb_bte_o  out  2`: Constant 2'b00.
- `en  in  1`: Enable. Low flushes the FIFO, clears `offset` and aborts any bus cycle.
- `adr  in  32`: Base byte address. Held stable while `en`=1.
- `sd_clk  in  1`: Read-side clock.
- `rd  in  1`: Pop request, `sd_clk` domain.
- `dat_o  out  32`: Head-of-FIFO word, `sd_clk` domain. Valid while `empty`=0.
- `full  out  1`: FIFO full, `clk` domain.
- `empty  out  1`: FIFO empty, `sd_clk` domain.

## Operation
- **Registers in the `clk` domain:**
  - `offset[31:0]`
  - a 2-state FSM: IDLE, REQ
  - write pointer `wptr[DEPTH_LOG2:0]`, binary and Gray copies
  - `flush`, a registered copy of `!en`
- **Registers in the `sd_clk` domain:** read pointer `rptr`, binary and Gray copies.
- **Pointer crossing:** each Gray pointer is synchronised into the other domain through 2 flops.
- **`full`:** `wptr` and the synchronised `rptr` differ only in the top two Gray bits.
- **`empty`:** `rptr` equals the synchronised `wptr`.
- **FIFO reset:** `rst | flush` asynchronously clears both pointer sets and all synchroniser flops. Memory contents are not cleared.
- **FSM, IDLE:**
  - Move to REQ when `en`=1, `flush`=0 and `full`=0.
  - `cyc`/`stb` go to 1 on that edge.
- **FSM, REQ:**
  - Hold `cyc`/`stb`=1 until `m_wb_ack_i`.
  - On the ack edge: write `m_wb_dat_i` to `mem[wptr]`, increment `wptr`, add `MEM_OFFSET` to `offset`, drop `cyc`/`stb` to 0 and return to IDLE.
- **Read side:**
  - `dat_o` = `mem[rptr]`, a combinational read of the memory array.
  - `rd`=1 with `empty`=0 increments `rptr` on the `sd_clk` edge.
  - `rd` while `empty`=1 is ignored.
- **`en` low:** on the next `clk` edge `cyc`/`stb`=0, FSM goes to IDLE, `offset`=0 and `flush`=1. An ack arriving in that cycle is ignored: no write, no offset change.
- **`en` returning high:** `flush` clears one edge later. The first request is issued on the following edge at address `adr`.
- **Reset values:**
  - `cyc`/`stb`/`we` = 0, `cti` = 0, `bte` = 0.
  - `offset` = 0, so `m_wb_adr_o` = `adr`.
  - `full` = 0, `empty` = 1, FSM = IDLE.

## Timing
- **Request rate:** a request is never issued while `full`=1.
  - At most 1 word per 2 `clk` cycles: a request cycle, then at least 1 IDLE cycle.
  - With a zero-wait slave: `cyc` high at edge N, ack sampled at N+1, `cyc` low at N+1, next request at N+2.
- **`full` on the write side:** asserts on the same edge as the write that fills the FIFO, so no overrun is possible.
- **`full` release after a pop:** `full` deasserts 2–3 `clk` edges after the `sd_clk` pop edge.
- **Write-to-visible latency:** after a write, `empty` deasserts 2–3 `sd_clk` edges later.
- **Wait states:** any number of wait states is allowed. `m_wb_adr_o` is stable for the whole REQ state.
- **Pointer wrap:** pointers wrap modulo 2^(DEPTH_LOG2+1). Behaviour is continuous across the wrap.
- **Address wrap:** `offset` wraps modulo 2^32, and `m_wb_adr_o` wraps the same way.
- **Reset mid-transaction:** asynchronous. All outputs take their reset values immediately; a pending ack is dropped.

## Test plan
- **Reset values:** assert `rst` -> `cyc`=`stb`=`we`=0, `full`=0, `empty`=1, `m_wb_adr_o`=`adr`.
- **Fill with reader idle:** `en`=1, `adr`=0x1000, zero-wait slave returning data equal to the address, `rd`=0 -> exactly 8 reads at 0x1000..0x101C. Then `full`=1 and no further `cyc`.
- **Drain:** from full, pulse `rd` 8 times on `sd_clk` (other ratio) -> `dat_o` sequence 0x1000..0x101C, then `empty`=1. Fetching resumes at 0x1020 once space is seen.
- **Wait states:** slave inserts 3 wait states -> `cyc`/`stb` held 4 cycles, address stable, exactly one FIFO write per ack.
- **Abort mid-transaction:** drop `en` while in REQ, with ack in the same cycle -> no write, `cyc`=0 next edge, `offset`=0, `empty`=1 within 3 `sd_clk` edges. Re-enable -> first address = `adr`.
- **Edge cases:** `rd` while empty -> no pointer change. `adr`=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/sd_tx_wb_fetcher_if.sv
// Wishbone classic-cycle master bus used by the SD transmit fetcher.
// The master modport is the fetcher; the slave modport is system memory.
interface sd_tx_wb_fetcher_if;
   logic [31:0] m_wb_adr_o;
   logic        m_wb_we_o;
   logic [31:0] m_wb_dat_i;
   logic        m_wb_cyc_o;
   logic        m_wb_stb_o;
   logic        m_wb_ack_i;
   logic [2:0]  m_wb_cti_o;
   logic [1:0]  m_wb_bte_o;

   modport master (
      output m_wb_adr_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
      input  m_wb_dat_i, m_wb_ack_i
   );

   modport slave (
      input  m_wb_adr_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
      output m_wb_dat_i, m_wb_ack_i
   );
endinterface

// File: rtl/sd_tx_wb_fetcher.sv
// Wishbone read engine feeding the SD transmit path through a dual-clock
// Gray-pointer FIFO; the write side runs on clk, the read side on sd_clk.
module sd_tx_wb_fetcher #(
   parameter int DEPTH_LOG2 = 3,
   parameter int MEM_OFFSET = 4
) (
   input  logic               clk,
   input  logic               rst,
   sd_tx_wb_fetcher_if.master wb,
   input  logic               en,
   input  logic [31:0]        adr,
   input  logic               sd_clk,
   input  logic               rd,
   output logic [31:0]        dat_o,
   output logic               full,
   output logic               empty
);
   localparam int PW = DEPTH_LOG2 + 1;

   typedef enum logic {IDLE, REQ} state_t;

   state_t          state;
   logic [31:0]     offset;
   logic            cyc;
   logic            flush;
   logic            fifo_rst;
   logic            wr_en;
   logic            rd_en;
   logic [31:0]     mem [2**DEPTH_LOG2];
   logic [PW-1:0]   wptr_bin, wptr_gray, wptr_bin_nxt;
   logic [PW-1:0]   rptr_bin, rptr_gray, rptr_bin_nxt;
   logic [PW-1:0]   rptr_gray_q1, rptr_gray_q2;
   logic [PW-1:0]   wptr_gray_q1, wptr_gray_q2;

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   assign wb.m_wb_adr_o = adr + offset;
   assign wb.m_wb_we_o  = 1'b0;
   assign wb.m_wb_cyc_o = cyc;
   assign wb.m_wb_stb_o = cyc;
   assign wb.m_wb_cti_o = 3'b000;
   assign wb.m_wb_bte_o = 2'b00;

   // Flush is a registered copy of !en, so the FIFO clears one edge after en drops
   assign fifo_rst     = rst | flush;
   assign wr_en        = (state == REQ) && wb.m_wb_ack_i && en;
   assign wptr_bin_nxt = wptr_bin + PW'(1);
   assign rptr_bin_nxt = rptr_bin + PW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) flush <= 1'b0;
      else     flush <= !en;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cyc    <= 1'b0;
         offset <= '0;
      end else if (!en) begin
         state  <= IDLE;
         cyc    <= 1'b0;
         offset <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!flush && !full) begin
                  state <= REQ;
                  cyc   <= 1'b1;
               end
            end
            REQ: begin
               if (wb.m_wb_ack_i) begin
                  state  <= IDLE;
                  cyc    <= 1'b0;
                  offset <= offset + 32'(MEM_OFFSET);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr_bin[DEPTH_LOG2-1:0]] <= wb.m_wb_dat_i;
   end

   always_ff @(posedge clk or posedge fifo_rst) begin
      if (fifo_rst) begin
         wptr_bin     <= '0;
         wptr_gray    <= '0;
         rptr_gray_q1 <= '0;
         rptr_gray_q2 <= '0;
      end else begin
         rptr_gray_q1 <= rptr_gray;
         rptr_gray_q2 <= rptr_gray_q1;
         if (wr_en) begin
            wptr_bin  <= wptr_bin_nxt;
            wptr_gray <= bin2gray(wptr_bin_nxt);
         end
      end
   end

   // Full when the Gray pointers differ in exactly the two top bits
   assign full = (wptr_gray == {~rptr_gray_q2[PW-1:PW-2], rptr_gray_q2[PW-3:0]});

   assign empty = (rptr_gray == wptr_gray_q2);
   assign rd_en = rd && !empty;
   assign dat_o = mem[rptr_bin[DEPTH_LOG2-1:0]];

   always_ff @(posedge sd_clk or posedge fifo_rst) begin
      if (fifo_rst) begin
         rptr_bin     <= '0;
         rptr_gray    <= '0;
         wptr_gray_q1 <= '0;
         wptr_gray_q2 <= '0;
      end else begin
         wptr_gray_q1 <= wptr_gray;
         wptr_gray_q2 <= wptr_gray_q1;
         if (rd_en) begin
            rptr_bin  <= rptr_bin_nxt;
            rptr_gray <= bin2gray(rptr_bin_nxt);
         end
      end
   end
endmodule

// File: tb/tb_sd_tx_wb_fetcher.sv
// Scoreboard bench for sd_tx_wb_fetcher: a memory slave model feeds words,
// an sd_clk reader pops them and compares against the expected-word queue.
module tb_sd_tx_wb_fetcher;
   logic        clk = 1'b0;
   logic        sd_clk = 1'b0;
   logic        rst;
   logic        en;
   logic        rd;
   logic [31:0] adr;
   logic [31:0] dat_o;
   logic        full;
   logic        empty;

   sd_tx_wb_fetcher_if wb ();

   sd_tx_wb_fetcher #(.DEPTH_LOG2(3), .MEM_OFFSET(4)) dut (
      .clk(clk), .rst(rst), .wb(wb), .en(en), .adr(adr),
      .sd_clk(sd_clk), .rd(rd), .dat_o(dat_o), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;
   always #7 sd_clk = ~sd_clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] expq[$];
   logic [31:0] req_log[$];
   int          len_log[$];
   logic [31:0] off = '0;
   logic [31:0] held = '0;
   int          n_writes = 0;
   int          n_pops = 0;
   int          cyc_len = 0;
   bit          cyc_prev = 1'b0;
   int          rd_mode = 0;
   int          pops_left = 0;
   int          fixed_waits = 0;
   bit          rand_waits = 1'b0;
   bit          rand_data = 1'b0;
   int          wcnt = 0;
   int          cur_waits = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Memory slave: answers each request after a chosen number of wait states
   always @(negedge clk) begin
      if (rst || !wb.m_wb_cyc_o) begin
         wb.m_wb_ack_i = 1'b0;
         wcnt = 0;
      end else begin
         if (wcnt == 0) cur_waits = rand_waits ? int'($urandom_range(0, 3)) : fixed_waits;
         if (wcnt >= cur_waits) begin
            wb.m_wb_ack_i = 1'b1;
            wb.m_wb_dat_i = rand_data ? $urandom : wb.m_wb_adr_o;
         end else begin
            wb.m_wb_ack_i = 1'b0;
         end
         wcnt++;
      end
   end

   // Reference model: a FIFO of accepted words and a running byte offset
   always @(posedge clk) begin
      if (rst || !en) begin
         off = '0;
         expq.delete();
      end else if (wb.m_wb_cyc_o && wb.m_wb_ack_i) begin
         expq.push_back(wb.m_wb_dat_i);
         off = off + 32'd4;
         n_writes++;
         len_log.push_back(cyc_len);
      end
   end

   // Bus monitor: request address, address stability, stb/we relations
   always @(negedge clk) begin
      if (rst) begin
         cyc_prev = 1'b0;
      end else begin
         if (wb.m_wb_cyc_o) begin
            if (!cyc_prev) begin
               chk("req_adr", wb.m_wb_adr_o, adr + off);
               req_log.push_back(wb.m_wb_adr_o);
               cyc_len = 1;
            end else begin
               chk("adr_stable", wb.m_wb_adr_o, held);
               cyc_len++;
            end
            held = wb.m_wb_adr_o;
         end
         chk("stb_eq_cyc", 32'(wb.m_wb_stb_o), 32'(wb.m_wb_cyc_o));
         chk("we_zero", 32'(wb.m_wb_we_o), 32'd0);
         cyc_prev = wb.m_wb_cyc_o;
      end
   end

   // Reader and data checker in the sd_clk domain
   always @(negedge sd_clk) begin
      case (rd_mode)
         1:       rd = 1'($urandom_range(0, 1));
         2:       rd = (pops_left > 0);
         3:       rd = 1'b1;
         default: rd = 1'b0;
      endcase
      if (rd && !empty && !rst) begin
         if (expq.size() == 0) begin
            chk("pop_unexpected", dat_o, 32'hxxxxxxxx);
         end else begin
            chk("dat_o", dat_o, expq.pop_front());
         end
         n_pops++;
         if (pops_left > 0) pops_left--;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int nw;
      int np;
      rst = 1'b1;
      en  = 1'b0;
      adr = 32'h0000_1000;
      repeat (3) @(negedge clk);
      chk("rst_cyc", 32'(wb.m_wb_cyc_o), 32'd0);
      chk("rst_stb", 32'(wb.m_wb_stb_o), 32'd0);
      chk("rst_we", 32'(wb.m_wb_we_o), 32'd0);
      chk("rst_cti", 32'(wb.m_wb_cti_o), 32'd0);
      chk("rst_bte", 32'(wb.m_wb_bte_o), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_adr", wb.m_wb_adr_o, 32'h0000_1000);

      // Fill with the reader idle
      rst = 1'b0;
      en  = 1'b1;
      k = 0;
      while (!full && k < 200) begin @(negedge clk); k++; end
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_writes", 32'(n_writes), 32'd8);
      chk("fill_reqs", 32'(req_log.size()), 32'd8);
      for (int i = 0; i < 8 && i < req_log.size(); i++)
         chk("fill_adr", req_log[i], 32'h0000_1000 + 32'(4 * i));
      nw = 0;
      repeat (20) begin @(negedge clk); if (wb.m_wb_cyc_o) nw++; end
      chk("full_no_cyc", 32'(nw), 32'd0);

      // Drain eight words on sd_clk; fetching resumes at the next address
      req_log.delete();
      pops_left = 8;
      rd_mode = 2;
      k = 0;
      while (!wb.m_wb_cyc_o && k < 200) begin @(negedge clk); k++; end
      chk("resume_adr", wb.m_wb_adr_o, 32'h0000_1020);
      k = 0;
      while (pops_left > 0 && k < 400) begin @(negedge clk); k++; end
      chk("drain_done", 32'(pops_left), 32'd0);

      // Three wait states per access
      fixed_waits = 3;
      rd_mode = 1;
      repeat (10) @(negedge clk);
      len_log.delete();
      k = 0;
      while (len_log.size() < 4 && k < 400) begin @(negedge clk); k++; end
      chk("ws_count", 32'(len_log.size() >= 4), 32'd1);
      for (int i = 0; i < 4 && i < len_log.size(); i++)
         chk("ws_cyc_len", 32'(len_log[i]), 32'd4);

      // Abort with an ack landing in the same cycle as en falling
      fixed_waits = 0;
      k = 0;
      do begin @(negedge clk); k++; end while (!wb.m_wb_cyc_o && k < 200);
      chk("abort_found_cyc", 32'(wb.m_wb_cyc_o), 32'd1);
      rd_mode = 0;
      en = 1'b0;
      nw = n_writes;
      @(posedge clk);
      #1;
      chk("abort_cyc", 32'(wb.m_wb_cyc_o), 32'd0);
      chk("abort_adr", wb.m_wb_adr_o, adr);
      chk("abort_no_write", 32'(n_writes), 32'(nw));
      k = 0;
      while (empty !== 1'b1 && k < 3) begin @(posedge sd_clk); k++; end
      #1;
      chk("abort_empty", 32'(empty), 32'd1);

      // Pop requests while empty must be ignored
      np = n_pops;
      rd_mode = 3;
      repeat (10) @(negedge sd_clk);
      rd_mode = 0;
      @(negedge clk);
      chk("rd_empty_pops", 32'(n_pops), 32'(np));
      chk("rd_empty_flag", 32'(empty), 32'd1);

      // Re-enable: flush clears, then the request goes out at the base address
      req_log.delete();
      en = 1'b1;
      @(negedge clk);
      chk("reen_wait", 32'(wb.m_wb_cyc_o), 32'd0);
      @(negedge clk);
      chk("reen_cyc", 32'(wb.m_wb_cyc_o), 32'd1);
      chk("reen_adr", wb.m_wb_adr_o, 32'h0000_1000);
      rd_mode = 1;
      repeat (60) @(negedge clk);

      // Address wrap at the top of the 32-bit space
      en = 1'b0;
      repeat (2) @(negedge clk);
      adr = 32'hFFFF_FFF8;
      req_log.delete();
      rand_data = 1'b1;
      en = 1'b1;
      k = 0;
      while (req_log.size() < 3 && k < 200) begin @(negedge clk); k++; end
      chk("wrap_reqs", 32'(req_log.size() >= 3), 32'd1);
      if (req_log.size() >= 3) begin
         chk("wrap_adr0", req_log[0], 32'hFFFF_FFF8);
         chk("wrap_adr1", req_log[1], 32'hFFFF_FFFC);
         chk("wrap_adr2", req_log[2], 32'h0000_0000);
      end

      // Random wait states, data and reader activity from a random base
      en = 1'b0;
      repeat (2) @(negedge clk);
      adr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      rand_waits = 1'b1;
      np = n_pops;
      en = 1'b1;
      repeat (800) @(negedge clk);
      chk("rand_progress", 32'(n_pops > np + 20), 32'd1);

      // Asynchronous reset in the middle of a request
      rand_waits = 1'b0;
      fixed_waits = 3;
      k = 0;
      do begin @(negedge clk); k++; end while (!wb.m_wb_cyc_o && k < 200);
      rst = 1'b1;
      #1;
      chk("arst_cyc", 32'(wb.m_wb_cyc_o), 32'd0);
      chk("arst_full", 32'(full), 32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      chk("arst_adr", wb.m_wb_adr_o, adr);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
